// File: rtl/i2c_pkg.sv
// Shared I2C definitions: protocol constants, target FSM state encoding and address match helper.
package i2c_pkg;

  localparam int unsigned BITS_PER_BYTE = 8;
  localparam int unsigned BIT_CNT_W     = 3;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } i2c_state_t;

  // General call (address 0) is never claimed.
  function automatic logic addr_match(input logic [6:0] rx_addr, input logic [6:0] own_addr);
    return (rx_addr == own_addr) && (rx_addr != 7'd0);
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA pad synchronizer with registered edge, START and STOP pulses.
// Pulses appear three clocks after the pin edge; sda_o is aligned with scl_rise_o.
module i2c_bus_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_det_o,
  output logic stop_det_o,
  output logic sda_o
);

  logic [2:0] scl_q;
  logic [2:0] sda_q;
  logic       scl_rise_q;
  logic       scl_fall_q;
  logic       start_q;
  logic       stop_q;

  // Sync stages reset to the idle-bus level so reset release never looks like an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_q      <= 3'b111;
      sda_q      <= 3'b111;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_q      <= {scl_q[1:0], scl_i};
      sda_q      <= {sda_q[1:0], sda_i};
      scl_rise_q <= scl_q[1] & ~scl_q[2];
      scl_fall_q <= ~scl_q[1] & scl_q[2];
      start_q    <= scl_q[1] & scl_q[2] & ~sda_q[1] & sda_q[2];
      stop_q     <= scl_q[1] & scl_q[2] & sda_q[1] & ~sda_q[2];
    end
  end

  assign scl_rise_o  = scl_rise_q;
  assign scl_fall_o  = scl_fall_q;
  assign start_det_o = start_q;
  assign stop_det_o  = stop_q;
  assign sda_o       = sda_q[2];

endmodule

// File: rtl/i2c_target_ctrl.sv
// I2C target controller: address match, register pointer write, auto-incrementing
// register-file writes and reads over a byte-wide strobe interface.
module i2c_target_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h42,
  parameter int unsigned REG_AW      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  output logic [REG_AW-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BITS_PER_BYTE - 1);

  logic scl_rise;
  logic scl_fall;
  logic start_det;
  logic stop_det;
  logic sda_s;

  i2c_bus_sync u_sync (
    .clk        (clk),
    .reset      (reset),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_det_o(start_det),
    .stop_det_o (stop_det),
    .sda_o      (sda_s)
  );

  i2c_state_t           state_q;
  logic [BIT_CNT_W-1:0] cnt_q;
  logic [7:0]           sh_q;
  logic [REG_AW-1:0]    addr_q;
  logic [7:0]           wdata_q;
  logic                 we_q;
  logic                 re_q;
  logic                 oe_q;
  logic                 busy_q;
  logic                 rw_q;
  logic                 ph_q;

  logic [7:0] rx_byte;
  logic       byte_done;

  assign rx_byte   = {sh_q[6:0], sda_s};
  assign byte_done = (cnt_q == LAST_BIT);

  // ph_q marks the second half of an ACK slot: 0 until the fall that opens the 9th clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      re_q    <= 1'b0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      rw_q    <= 1'b0;
      ph_q    <= 1'b0;
    end else begin
      we_q <= 1'b0;
      re_q <= 1'b0;
      if (we_q) addr_q <= addr_q + REG_AW'(1);
      if (re_q) sh_q <= reg_rdata;

      if (stop_det) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
        ph_q    <= 1'b0;
      end else if (start_det) begin
        state_q <= ST_ADDR;
        cnt_q   <= '0;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
        ph_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_ADDR: begin
            if (scl_rise) begin
              sh_q  <= rx_byte;
              cnt_q <= cnt_q + BIT_CNT_W'(1);
              if (byte_done) begin
                if (addr_match(rx_byte[7:1], TARGET_ADDR)) begin
                  state_q <= ST_ADDR_ACK;
                  busy_q  <= 1'b1;
                  rw_q    <= rx_byte[0];
                  ph_q    <= 1'b0;
                end else begin
                  state_q <= ST_WAIT_STOP;
                end
              end
            end
          end

          ST_ADDR_ACK: begin
            if (scl_rise && ph_q && rw_q) re_q <= 1'b1;
            if (scl_fall) begin
              if (!ph_q) begin
                oe_q <= ~I2C_ACK;
                ph_q <= 1'b1;
              end else begin
                ph_q  <= 1'b0;
                cnt_q <= '0;
                if (rw_q) begin
                  oe_q    <= ~sh_q[7];
                  state_q <= ST_RDATA;
                end else begin
                  oe_q    <= 1'b0;
                  state_q <= ST_PTR;
                end
              end
            end
          end

          ST_PTR: begin
            if (scl_rise) begin
              sh_q  <= rx_byte;
              cnt_q <= cnt_q + BIT_CNT_W'(1);
              if (byte_done) begin
                addr_q  <= rx_byte[REG_AW-1:0];
                state_q <= ST_PTR_ACK;
                ph_q    <= 1'b0;
              end
            end
          end

          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              if (!ph_q) begin
                oe_q <= ~I2C_ACK;
                ph_q <= 1'b1;
              end else begin
                oe_q    <= 1'b0;
                ph_q    <= 1'b0;
                cnt_q   <= '0;
                state_q <= ST_WDATA;
              end
            end
          end

          ST_WDATA: begin
            if (scl_rise) begin
              sh_q  <= rx_byte;
              cnt_q <= cnt_q + BIT_CNT_W'(1);
              if (byte_done) begin
                we_q    <= 1'b1;
                wdata_q <= rx_byte;
                state_q <= ST_WDATA_ACK;
                ph_q    <= 1'b0;
              end
            end
          end

          ST_RDATA: begin
            if (scl_rise) begin
              cnt_q <= cnt_q + BIT_CNT_W'(1);
              if (byte_done) begin
                state_q <= ST_RDATA_ACK;
                ph_q    <= 1'b0;
              end
            end
            if (scl_fall) begin
              sh_q <= {sh_q[6:0], 1'b0};
              oe_q <= ~sh_q[6];
            end
          end

          // Master owns SDA for the 9th clock; its ACK fetches and preloads the next byte.
          ST_RDATA_ACK: begin
            if (scl_rise && ph_q) begin
              if (sda_s == I2C_NACK) begin
                state_q <= ST_WAIT_STOP;
                busy_q  <= 1'b0;
                ph_q    <= 1'b0;
              end else begin
                addr_q <= addr_q + REG_AW'(1);
                re_q   <= 1'b1;
              end
            end
            if (scl_fall) begin
              if (!ph_q) begin
                oe_q <= 1'b0;
                ph_q <= 1'b1;
              end else begin
                oe_q    <= ~sh_q[7];
                ph_q    <= 1'b0;
                cnt_q   <= '0;
                state_q <= ST_RDATA;
              end
            end
          end

          default: ;
        endcase
      end
    end
  end

  assign sda_oe    = oe_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = wdata_q;
  assign reg_we    = we_q;
  assign reg_re    = re_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_ctrl.sv
// Bench for i2c_target_ctrl: bit-level I2C master, register-file model and
// transaction-level expectations for directed and randomized transfers.
module tb_i2c_target_ctrl;

  localparam int unsigned REG_AW = 4;
  localparam int NREG = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl_m;
  logic       sda_m;
  logic       sda_bus;
  logic       sda_oe;
  logic [3:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata;
  logic       busy;

  logic [7:0]  rf       [NREG];
  logic [7:0]  init_val [NREG];
  logic [7:0]  ref_mem  [NREG];
  logic [7:0]  wd       [8];
  logic [11:0] obs_we   [$];
  logic [3:0]  obs_re   [$];
  int          overlap   = 0;
  int          busy_cyc  = 0;
  int          n_assert  = 0;
  int          n_fail    = 0;

  assign sda_bus   = sda_m & ~sda_oe;
  assign reg_rdata = rf[reg_addr];

  always #5 clk = ~clk;

  i2c_target_ctrl #(.TARGET_ADDR(7'h42), .REG_AW(REG_AW)) dut (
    .clk      (clk),
    .reset    (reset),
    .scl_i    (scl_m),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .reg_addr (reg_addr),
    .reg_wdata(reg_wdata),
    .reg_we   (reg_we),
    .reg_re   (reg_re),
    .reg_rdata(reg_rdata),
    .busy     (busy)
  );

  // Register file and strobe monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= init_val[i];
    end else if (reg_we) begin
      rf[reg_addr] <= reg_wdata;
    end
    if (reg_we) obs_we.push_back({reg_addr, reg_wdata});
    if (reg_re) obs_re.push_back(reg_addr);
    if (reg_we && reg_re) overlap <= overlap + 1;
    if (busy) busy_cyc <= busy_cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic ck(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period (8 clk low, 8 clk high); optional SDA glitching while SCL is low.
  task automatic bit_xfer(input logic b, input bit glitch, output logic rb);
    ck(2);
    if (glitch) begin
      sda_m = ~b; ck(1);
      sda_m = b;  ck(1);
      sda_m = ~b; ck(1);
    end
    sda_m = b;
    ck(glitch ? 3 : 6);
    scl_m = 1'b1;
    ck(4);
    rb = sda_bus;
    ck(4);
    scl_m = 1'b0;
  endtask

  task automatic i2c_start();
    ck(2);
    sda_m = 1'b1; ck(6);
    scl_m = 1'b1; ck(6);
    sda_m = 1'b0; ck(6);
    scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    ck(2);
    sda_m = 1'b0; ck(6);
    scl_m = 1'b1; ck(6);
    sda_m = 1'b1; ck(6);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit glitch, output logic ack);
    logic rb;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], glitch, rb);
    bit_xfer(1'b1, 1'b0, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, 1'b0, rb);
      b[i] = rb;
    end
    bit_xfer(mack, 1'b0, rb);
  endtask

  // Pointer write followed by n data bytes taken from wd[].
  task automatic wr_txn(input logic [7:0] ptr, input int n, input bit glitch);
    int   base = obs_we.size();
    int   idx;
    logic ack;
    i2c_start();
    send_byte(8'h84, 1'b0, ack);
    check("wr_addr_ack", 32'(ack), 32'd0);
    send_byte(ptr, 1'b0, ack);
    check("wr_ptr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      send_byte(wd[i], glitch, ack);
      check("wr_data_ack", 32'(ack), 32'd0);
      idx = (int'(ptr) + i) % NREG;
      ref_mem[idx] = wd[i];
    end
    check("wr_busy", 32'(busy), 32'd1);
    i2c_stop();
    check("wr_busy_after_stop", 32'(busy), 32'd0);
    check("wr_we_count", 32'(obs_we.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < obs_we.size(); i++) begin
      idx = (int'(ptr) + i) % NREG;
      check("wr_we_addr_data", 32'(obs_we[base + i]), 32'({4'(idx), wd[i]}));
    end
    check("wr_final_ptr", 32'(reg_addr), 32'((int'(ptr) + n) % NREG));
  endtask

  // Pointer write, repeated START, then n bytes read with ACK on all but the last.
  task automatic rd_txn(input logic [7:0] ptr, input int n);
    int         base = obs_re.size();
    int         idx;
    logic       ack;
    logic [7:0] d;
    i2c_start();
    send_byte(8'h84, 1'b0, ack);
    check("rd_addr_w_ack", 32'(ack), 32'd0);
    send_byte(ptr, 1'b0, ack);
    check("rd_ptr_ack", 32'(ack), 32'd0);
    i2c_start();
    send_byte(8'h85, 1'b0, ack);
    check("rd_addr_r_ack", 32'(ack), 32'd0);
    for (int i = 0; i < n; i++) begin
      recv_byte((i == n - 1) ? 1'b1 : 1'b0, d);
      idx = (int'(ptr) + i) % NREG;
      check("rd_data", 32'(d), 32'(ref_mem[idx]));
    end
    check("rd_busy_after_nack", 32'(busy), 32'd0);
    i2c_stop();
    check("rd_re_count", 32'(obs_re.size() - base), 32'(n));
    for (int i = 0; i < n && base + i < obs_re.size(); i++) begin
      idx = (int'(ptr) + i) % NREG;
      check("rd_re_addr", 32'(obs_re[base + i]), 32'(idx));
    end
  endtask

  initial begin
    logic       ack;
    logic       rb;
    logic [7:0] ptr;
    int         we_base;
    int         re_base;
    int         busy_base;
    int         n;

    for (int i = 0; i < NREG; i++) init_val[i] = 8'($urandom);
    ref_mem = init_val;
    reset = 1'b1;
    scl_m = 1'b1;
    sda_m = 1'b1;
    ck(4);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_reg_addr", 32'(reg_addr), 32'd0);
    check("rst_reg_wdata", 32'(reg_wdata), 32'd0);
    check("rst_reg_we", 32'(reg_we), 32'd0);
    check("rst_reg_re", 32'(reg_re), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    ck(8);

    // Directed write: pointer 3, two data bytes.
    wd[0] = 8'hA5;
    wd[1] = 8'h5A;
    wr_txn(8'h03, 2, 1'b0);

    // Directed read across the top of the register space.
    rd_txn(8'h0F, 2);

    // Address mismatch and general call: NACK, no strobes, never busy.
    we_base   = obs_we.size();
    re_base   = obs_re.size();
    busy_base = busy_cyc;
    i2c_start();
    send_byte(8'h86, 1'b0, ack);
    check("mismatch_nack", 32'(ack), 32'd1);
    send_byte(8'h3C, 1'b0, ack);
    check("mismatch_data_nack", 32'(ack), 32'd1);
    i2c_stop();
    i2c_start();
    send_byte(8'h00, 1'b0, ack);
    check("gencall_nack", 32'(ack), 32'd1);
    i2c_stop();
    check("mismatch_no_we", 32'(obs_we.size() - we_base), 32'd0);
    check("mismatch_no_re", 32'(obs_re.size() - re_base), 32'd0);
    check("mismatch_never_busy", 32'(busy_cyc - busy_base), 32'd0);

    // Abort: STOP after four bits of a data byte discards it.
    ptr     = 8'($urandom);
    we_base = obs_we.size();
    i2c_start();
    send_byte(8'h84, 1'b0, ack);
    check("abort_addr_ack", 32'(ack), 32'd0);
    send_byte(ptr, 1'b0, ack);
    check("abort_ptr_ack", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) bit_xfer(1'($urandom), 1'b0, rb);
    i2c_stop();
    check("abort_no_we", 32'(obs_we.size() - we_base), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ptr_kept", 32'(reg_addr), 32'(ptr[3:0]));
    wd[0] = 8'($urandom);
    wr_txn(8'($urandom), 1, 1'b0);

    // SDA glitches while SCL is low must not look like START/STOP.
    for (int i = 0; i < 3; i++) wd[i] = 8'($urandom);
    wr_txn(8'($urandom), 3, 1'b1);

    // Randomized mix of writes and reads against the reference memory.
    for (int t = 0; t < 10; t++) begin
      ptr = 8'($urandom);
      n   = int'($urandom_range(1, 4));
      if ($urandom_range(0, 1) == 0) begin
        for (int i = 0; i < n; i++) wd[i] = 8'($urandom);
        wr_txn(ptr, n, 1'b0);
      end else begin
        rd_txn(ptr, n);
      end
    end

    // Async reset while the target drives the address ACK.
    i2c_start();
    for (int i = 7; i >= 0; i--) bit_xfer(((8'h84 >> i) & 8'h01) != 8'h00, 1'b0, rb);
    ck(6);
    check("ack_driven_before_reset", 32'(sda_oe), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_sda_oe", 32'(sda_oe), 32'd0);
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_reg_addr", 32'(reg_addr), 32'd0);
    check("async_rst_reg_we", 32'(reg_we), 32'd0);
    check("async_rst_reg_re", 32'(reg_re), 32'd0);
    check("async_rst_reg_wdata", 32'(reg_wdata), 32'd0);
    ck(2);
    scl_m = 1'b1;
    sda_m = 1'b1;
    ck(4);
    reset = 1'b0;
    ref_mem = init_val;
    ck(8);

    // Target must be fully usable after reset.
    for (int i = 0; i < 2; i++) wd[i] = 8'($urandom);
    wr_txn(8'h0E, 2, 1'b0);
    rd_txn(8'h0E, 3);

    check("we_re_never_overlap", 32'(overlap), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
